// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the display scheduler; no logic, no latency.
// Optional SEG_DISP_SCHED_URGENT_EN only affects seg_disp_sched, not this package.
package seg_disp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int DISP_W           = 32;
  localparam int DWELL_CYCLES_DEF = 50000000;
  localparam int MAX_SRC          = 8;
  localparam logic [MAX_SRC-1:0] GRANT_ZERO = '0;

endpackage

// File: rtl/seg_rr_pick.sv
// Round-robin pick: purely combinational, searches last+1 .. last (wrapping), no backpressure.
// pick is only meaningful when any is high.
module seg_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares the 32-bit display load between requesters, round robin with fixed dwell; req->grant/load 1 cycle.
// No backpressure; define SEG_DISP_SCHED_URGENT_EN to add the urgent preemption input.
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = 2,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DISP_W-1:0] data,
`ifdef SEG_DISP_SCHED_URGENT_EN
  input  logic [NUM_SRC-1:0]        urgent,
`endif
  output logic [NUM_SRC-1:0]        grant,
  output logic [SRC_W-1:0]          src_id,
  output logic                      active,
  output logic [DISP_W-1:0]         load,
  output logic                      dwell_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DISP_W-1:0]    load_q, load_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic [SRC_W-1:0]     rr_pick;
  logic                 rr_any;
  logic                 go, stop;
  logic [SRC_W-1:0]     go_idx;

  seg_rr_pick #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .pick (rr_pick),
    .any  (rr_any)
  );

`ifdef SEG_DISP_SCHED_URGENT_EN
  logic [NUM_SRC-1:0] urg;
  logic               urg_any;
  logic [SRC_W-1:0]   urg_idx;

  // Descending scan so the lowest urgent index is the one left standing.
  always_comb begin
    urg     = req & urgent;
    urg_any = 1'b0;
    urg_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (urg[i]) begin
        urg_any = 1'b1;
        urg_idx = SRC_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    src_d    = src_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    active_d = active_q;
    done_d   = 1'b0;
    go       = 1'b0;
    stop     = 1'b0;
    go_idx   = rr_pick;

    case (state_q)
      IDLE: go = rr_any;
      SHOW: begin
        if (!req[src_q]) begin
          go   = rr_any;
          stop = !rr_any;
        end else if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
          go     = rr_any;
          stop   = !rr_any;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          load_d = data[int'(src_q)*DISP_W +: DISP_W];
        end
      end
      default: stop = 1'b1;
    endcase

`ifdef SEG_DISP_SCHED_URGENT_EN
    // Holding the counter at 0 both freezes rotation and gives a fresh dwell once urgency clears.
    if (urg_any) begin
      done_d = 1'b0;
      stop   = 1'b0;
      if (state_q == SHOW && src_q == urg_idx) begin
        go     = 1'b0;
        cnt_d  = '0;
        load_d = data[int'(src_q)*DISP_W +: DISP_W];
      end else begin
        go     = 1'b1;
        go_idx = urg_idx;
      end
    end
`endif

    if (go) begin
      state_d  = SHOW;
      grant_d  = NUM_SRC'(1) << go_idx;
      src_d    = go_idx;
      last_d   = go_idx;
      load_d   = data[int'(go_idx)*DISP_W +: DISP_W];
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      grant_d  = GRANT_ZERO[NUM_SRC-1:0];
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_ZERO[NUM_SRC-1:0];
      src_q    <= '0;
      last_q   <= SRC_W'(NUM_SRC - 1);
      cnt_q    <= '0;
      load_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign grant      = grant_q;
  assign src_id     = src_q;
  assign active     = active_q;
  assign load       = load_q;
  assign dwell_done = done_q;

endmodule
